// File: rtl/bus_arbiter_2.sv
// rtl/bus_arbiter_2.sv - two-host, one-target system bus arbiter with per-transaction watchdog
// Grants one host at a time, holds the grant until dev_ready, and force-completes hung accesses.

module bus_arbiter_2 #(
  parameter int FIXED_PRIORITY = 0,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic [31:0] h0_addr,
  input  logic [31:0] h0_wdata,
  input  logic [3:0]  h0_wmask,
  input  logic        h0_wen,
  input  logic        h0_ren,
  output logic [31:0] h0_rdata,
  output logic        h0_ready,

  input  logic [31:0] h1_addr,
  input  logic [31:0] h1_wdata,
  input  logic [3:0]  h1_wmask,
  input  logic        h1_wen,
  input  logic        h1_ren,
  output logic [31:0] h1_rdata,
  output logic        h1_ready,

  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic [3:0]  dev_wmask,
  output logic        dev_wen,
  output logic        dev_ren,
  input  logic [31:0] dev_rdata,
  input  logic        dev_ready,

  output logic [1:0]  grant,
  output logic        bus_error,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam bit             WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_nx;
  logic             last_grant;
  logic             last_grant_nx;
  logic [CNT_W-1:0] wd_cnt;
  logic [7:0]       err_cnt_q;

  logic h0_req;
  logic h1_req;
  logic owner_req;
  logic in_grant;
  logic done;
  logic tmo;

  assign h0_req    = h0_ren | h0_wen;
  assign h1_req    = h1_ren | h1_wen;
  assign in_grant  = (state == GRANT0) || (state == GRANT1);
  assign owner_req = (state == GRANT1) ? h1_req : h0_req;

  // A withdrawn request gets neither a ready nor an error; reset suppresses both.
  assign done = rst_n & in_grant & owner_req & dev_ready;
  assign tmo  = rst_n & in_grant & owner_req & ~dev_ready & WD_EN & (wd_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      wd_cnt     <= '0;
      err_cnt_q  <= 8'd0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      // Every grant is entered from IDLE, so the counter is zero on entry.
      if (state == IDLE) begin
        wd_cnt <= '0;
      end else if (!dev_ready && WD_EN) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (tmo && err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    case (state)
      IDLE: begin
        if (h0_req && h1_req) begin
          state_nx = ((FIXED_PRIORITY != 0) || last_grant) ? GRANT0 : GRANT1;
        end else if (h0_req) begin
          state_nx = GRANT0;
        end else if (h1_req) begin
          state_nx = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (done || tmo) begin
          state_nx      = IDLE;
          last_grant_nx = (state == GRANT1);
        end else if (!owner_req) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    grant     = 2'b00;
    dev_addr  = 32'd0;
    dev_wdata = 32'd0;
    dev_wmask = 4'd0;
    dev_wen   = 1'b0;
    dev_ren   = 1'b0;
    h0_ready  = 1'b0;
    h0_rdata  = 32'd0;
    h1_ready  = 1'b0;
    h1_rdata  = 32'd0;
    case (state)
      GRANT0: begin
        grant     = 2'b01;
        dev_addr  = h0_addr;
        dev_wdata = h0_wdata;
        dev_wmask = h0_wmask;
        dev_wen   = h0_wen & ~tmo;
        dev_ren   = h0_ren & ~tmo;
        h0_ready  = done | tmo;
        h0_rdata  = tmo ? 32'd0 : dev_rdata;
      end
      GRANT1: begin
        grant     = 2'b10;
        dev_addr  = h1_addr;
        dev_wdata = h1_wdata;
        dev_wmask = h1_wmask;
        dev_wen   = h1_wen & ~tmo;
        dev_ren   = h1_ren & ~tmo;
        h1_ready  = done | tmo;
        h1_rdata  = tmo ? 32'd0 : dev_rdata;
      end
      default: begin
      end
    endcase
  end

  assign bus_error = tmo;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_bus_arbiter_2.sv
// tb/tb_bus_arbiter_2.sv - bench for bus_arbiter_2
// Round-robin and fixed-priority instances share stimulus; both run a 16-cycle watchdog.

module tb_bus_arbiter_2;

  localparam logic [31:0] H0_WDATA = 32'h1234_5678;
  localparam logic [31:0] H1_WDATA = 32'hA5A5_A5A5;
  localparam logic [31:0] H1_ADDR  = 32'h8000_0000;
  localparam logic [31:0] A100     = 32'h0000_0100;
  localparam logic [31:0] A40      = 32'h0000_0040;
  localparam int          OW       = 147;

  typedef struct {
    logic        r;
    logic        h0r;
    logic        h0w;
    logic        h1r;
    logic        dr;
    logic [31:0] rd;
    logic [31:0] a0;
    logic [1:0]  g;
    logic        r0;
    logic        r1;
    logic [1:0]  fg;
    logic        fr0;
    logic        fr1;
    logic        eerr;
    logic [7:0]  ec;
    logic        chk;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] h0_addr, h1_addr, h0_wdata, h1_wdata, dev_rdata;
  logic [3:0]  h0_wmask, h1_wmask;
  logic        h0_wen, h0_ren, h1_wen, h1_ren, dev_ready;

  logic [31:0] a_h0_rdata, a_h1_rdata, a_dev_addr, a_dev_wdata;
  logic        a_h0_ready, a_h1_ready, a_dev_wen, a_dev_ren, a_bus_error;
  logic [3:0]  a_dev_wmask;
  logic [1:0]  a_grant;
  logic [7:0]  a_err_count;

  logic [31:0] b_h0_rdata, b_h1_rdata, b_dev_addr, b_dev_wdata;
  logic        b_h0_ready, b_h1_ready, b_dev_wen, b_dev_ren, b_bus_error;
  logic [3:0]  b_dev_wmask;
  logic [1:0]  b_grant;
  logic [7:0]  b_err_count;

  int   total = 0;
  int   bad   = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  bus_arbiter_2 #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(16), .CNT_W(8)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .h0_addr(h0_addr), .h0_wdata(h0_wdata), .h0_wmask(h0_wmask), .h0_wen(h0_wen), .h0_ren(h0_ren),
    .h0_rdata(a_h0_rdata), .h0_ready(a_h0_ready),
    .h1_addr(h1_addr), .h1_wdata(h1_wdata), .h1_wmask(h1_wmask), .h1_wen(h1_wen), .h1_ren(h1_ren),
    .h1_rdata(a_h1_rdata), .h1_ready(a_h1_ready),
    .dev_addr(a_dev_addr), .dev_wdata(a_dev_wdata), .dev_wmask(a_dev_wmask),
    .dev_wen(a_dev_wen), .dev_ren(a_dev_ren), .dev_rdata(dev_rdata), .dev_ready(dev_ready),
    .grant(a_grant), .bus_error(a_bus_error), .err_count(a_err_count)
  );

  bus_arbiter_2 #(.FIXED_PRIORITY(1), .TIMEOUT_CYCLES(16), .CNT_W(8)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .h0_addr(h0_addr), .h0_wdata(h0_wdata), .h0_wmask(h0_wmask), .h0_wen(h0_wen), .h0_ren(h0_ren),
    .h0_rdata(b_h0_rdata), .h0_ready(b_h0_ready),
    .h1_addr(h1_addr), .h1_wdata(h1_wdata), .h1_wmask(h1_wmask), .h1_wen(h1_wen), .h1_ren(h1_ren),
    .h1_rdata(b_h1_rdata), .h1_ready(b_h1_ready),
    .dev_addr(b_dev_addr), .dev_wdata(b_dev_wdata), .dev_wmask(b_dev_wmask),
    .dev_wen(b_dev_wen), .dev_ren(b_dev_ren), .dev_rdata(dev_rdata), .dev_ready(dev_ready),
    .grant(b_grant), .bus_error(b_bus_error), .err_count(b_err_count)
  );

  task automatic add2(input logic r, h0r, h0w, h1r, dr, input logic [31:0] rd, a0,
                      input logic [1:0] g, input logic r0, r1, eerr, input logic [7:0] ec,
                      input logic chk, input logic [1:0] fg, input logic fr0, fr1);
    vec_t v;
    v.r = r; v.h0r = h0r; v.h0w = h0w; v.h1r = h1r; v.dr = dr; v.rd = rd; v.a0 = a0;
    v.g = g; v.r0 = r0; v.r1 = r1; v.fg = fg; v.fr0 = fr0; v.fr1 = fr1;
    v.eerr = eerr; v.ec = ec; v.chk = chk;
    vq.push_back(v);
  endtask

  task automatic add(input logic r, h0r, h0w, h1r, dr, input logic [31:0] rd, a0,
                     input logic [1:0] g, input logic r0, r1, eerr, input logic [7:0] ec,
                     input logic chk);
    add2(r, h0r, h0w, h1r, dr, rd, a0, g, r0, r1, eerr, ec, chk, g, r0, r1);
  endtask

  // Expected outputs: the owner's request fields pass through, killed on a watchdog cycle.
  function automatic logic [OW-1:0] exp_of(input vec_t v, input logic [1:0] g, input logic r0, r1);
    logic [31:0] addr, wd, rd0, rd1;
    logic [3:0]  wm;
    logic        ren, wen;
    addr = 32'd0; wd = 32'd0; wm = 4'd0; ren = 1'b0; wen = 1'b0; rd0 = 32'd0; rd1 = 32'd0;
    if (g == 2'b01) begin
      addr = v.a0; wd = H0_WDATA; wm = 4'hF;
      ren = v.h0r & ~v.eerr; wen = v.h0w & ~v.eerr;
      rd0 = v.eerr ? 32'd0 : v.rd;
    end else if (g == 2'b10) begin
      addr = H1_ADDR; wd = H1_WDATA; wm = 4'h3;
      ren = v.h1r & ~v.eerr;
      rd1 = v.eerr ? 32'd0 : v.rd;
    end
    return {g, ren, wen, addr, wd, wm, r0, r1, rd0, rd1, v.eerr, v.ec};
  endfunction

  function automatic logic [OW-1:0] got_rr();
    return {a_grant, a_dev_ren, a_dev_wen, a_dev_addr, a_dev_wdata, a_dev_wmask,
            a_h0_ready, a_h1_ready, a_h0_rdata, a_h1_rdata, a_bus_error, a_err_count};
  endfunction

  function automatic logic [OW-1:0] got_fp();
    return {b_grant, b_dev_ren, b_dev_wen, b_dev_addr, b_dev_wdata, b_dev_wmask,
            b_h0_ready, b_h1_ready, b_h0_rdata, b_h1_rdata, b_bus_error, b_err_count};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  initial begin
    int          cyc;
    logic        seen;
    logic        be;
    logic [31:0] rdv;
    logic [1:0]  g;
    logic [1:0]  fg;

    rst_n = 1'b0; h0_addr = A100; h1_addr = H1_ADDR;
    h0_wdata = H0_WDATA; h1_wdata = H1_WDATA; h0_wmask = 4'hF; h1_wmask = 4'h3;
    h0_wen = 1'b0; h0_ren = 1'b0; h1_wen = 1'b0; h1_ren = 1'b0;
    dev_ready = 1'b0; dev_rdata = 32'd0;

    // reset
    add(0,0,0,0,0, 32'd0, A100, 2'b00, 0,0,0, 8'd0, 0);
    add(0,0,0,0,0, 32'd0, A100, 2'b00, 0,0,0, 8'd0, 1);
    // port 0 read, device ready two cycles after dev_ren rises
    add(1,1,0,0,0, 32'd0,         A100, 2'b00, 0,0,0, 8'd0, 1);
    add(1,1,0,0,0, 32'd0,         A100, 2'b01, 0,0,0, 8'd0, 1);
    add(1,1,0,0,0, 32'd0,         A100, 2'b01, 0,0,0, 8'd0, 1);
    add(1,1,0,0,1, 32'hDEADBEEF,  A100, 2'b01, 1,0,0, 8'd0, 1);
    add(1,0,0,0,0, 32'd0,         A100, 2'b00, 0,0,0, 8'd0, 1);
    add(0,0,0,0,0, 32'd0,         A100, 2'b00, 0,0,0, 8'd0, 1);
    // both request every cycle, device always ready
    for (int i = 0; i < 16; i++) begin
      g  = (i % 2 == 0) ? 2'b00 : ((i % 4 == 1) ? 2'b01 : 2'b10);
      fg = (i % 2 == 0) ? 2'b00 : 2'b01;
      add2(1,1,0,1,1, 32'hCAFE0000 + 32'(i), A100, g, g == 2'b01, g == 2'b10, 0, 8'd0, 1,
           fg, fg == 2'b01, 1'b0);
    end
    // h1 read, device never ready: forced completion on the 16th grant cycle
    add(1,0,0,0,0, 32'd0, A100, 2'b00, 0,0,0, 8'd0, 1);
    add(1,0,0,1,0, 32'd0, A100, 2'b00, 0,0,0, 8'd0, 1);
    for (int j = 1; j < 16; j++) add(1,0,0,1,0, 32'd0, A100, 2'b10, 0,0,0, 8'd0, 1);
    add(1,0,0,1,0, 32'h55AA55AA, A100, 2'b10, 0,1,1, 8'd0, 1);
    add(1,0,0,0,0, 32'd0,        A100, 2'b00, 0,0,0, 8'd1, 1);
    // device ready exactly on the 16th grant cycle: normal completion wins
    add(1,0,0,1,0, 32'd0, A100, 2'b00, 0,0,0, 8'd1, 1);
    for (int j = 1; j < 16; j++) add(1,0,0,1,0, 32'd0, A100, 2'b10, 0,0,0, 8'd1, 1);
    add(1,0,0,1,1, 32'h600DF00D, A100, 2'b10, 0,1,0, 8'd1, 1);
    add(1,0,0,0,0, 32'd0,        A100, 2'b00, 0,0,0, 8'd1, 1);
    // reset in the 2nd grant cycle of a write, dev_ready during reset
    add(1,0,1,0,0, 32'd0, A40, 2'b00, 0,0,0, 8'd1, 1);
    add(1,0,1,0,0, 32'd0, A40, 2'b01, 0,0,0, 8'd1, 1);
    add(0,0,1,0,0, 32'd0, A40, 2'b01, 0,0,0, 8'd1, 1);
    add(0,0,1,0,1, 32'd0, A40, 2'b00, 0,0,0, 8'd0, 1);
    add(1,0,1,1,1, 32'd0, A40, 2'b00, 0,0,0, 8'd0, 1);
    add(1,0,1,1,0, 32'd0, A40, 2'b01, 0,0,0, 8'd0, 1);
    // requester withdraws mid-grant: no ready even with dev_ready high
    add(1,0,0,0,1, 32'd0, A40, 2'b01, 0,0,0, 8'd0, 1);
    add(1,0,0,0,0, 32'd0, A40, 2'b00, 0,0,0, 8'd0, 1);

    foreach (vq[k]) begin
      @(negedge clk);
      rst_n = vq[k].r; h0_ren = vq[k].h0r; h0_wen = vq[k].h0w; h1_ren = vq[k].h1r;
      dev_ready = vq[k].dr; dev_rdata = vq[k].rd; h0_addr = vq[k].a0;
      #1;
      if (vq[k].chk) begin
        check($sformatf("vec%0d_rr", k), got_rr(), exp_of(vq[k], vq[k].g, vq[k].r0, vq[k].r1));
        check($sformatf("vec%0d_fp", k), got_fp(), exp_of(vq[k], vq[k].fg, vq[k].fr0, vq[k].fr1));
      end
    end

    // repeated port 0 timeouts drive err_count into saturation
    h0_addr = A100; dev_ready = 1'b0; dev_rdata = 32'h0BAD0BAD;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      h0_ren = 1'b1; h1_ren = 1'b0; h0_wen = 1'b0;
      cyc = 0; seen = 1'b0; be = 1'b0; rdv = 32'hFFFF_FFFF;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge clk);
        #1;
        cyc++;
        if (a_h0_ready) begin
          seen = 1'b1; be = a_bus_error; rdv = a_h0_rdata;
        end
      end
      @(negedge clk);
      h0_ren = 1'b0;
      #1;
      if (k == 0 || k == 255) begin
        check($sformatf("tmo%0d_cycles", k), OW'(cyc), OW'(16));
        check($sformatf("tmo%0d_err_rdata", k), OW'({be, rdv}), OW'({1'b1, 32'd0}));
      end
      if (k == 0)   check("err_count_first", OW'(a_err_count), OW'(8'd1));
      if (k == 254) check("err_count_255", OW'(a_err_count), OW'(8'd255));
      if (k == 255) check("err_count_sat", OW'(a_err_count), OW'(8'd255));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_2.md
Name: bus_arbiter_2

Overview:
- Two-host, one-target arbiter for the SoC system bus. It lets the CPU core (port 0) and a secondary master (port 1, e.g. debug loader or DMA) share the host side of the bus hub.
- Grants one requester at a time and holds the grant until the downstream transaction completes.
- Runs a watchdog per transaction so that an access to an address no device decodes can never hang a master.

Parameters:
- FIXED_PRIORITY, 0: 0 = round-robin; 1 = port 0 always wins ties.
- TIMEOUT_CYCLES, 255: maximum grant cycles without dev_ready before a forced completion. 0 disables the watchdog.
- CNT_W, 8: width of the watchdog counter; must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  core clock; all logic rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- h0_addr / h1_addr  in  32  requester byte address.
- h0_wdata / h1_wdata  in  32  write data.
- h0_wmask / h1_wmask  in  4  byte write mask.
- h0_wen / h1_wen  in  1  write request, level, held until ready.
- h0_ren / h1_ren  in  1  read request, level, held until ready.
- h0_rdata / h1_rdata  out  32  read data, valid while the matching ready is high.
- h0_ready / h1_ready  out  1  one-cycle completion pulse.
- dev_addr  out  32  downstream address.
- dev_wdata  out  32  downstream write data.
- dev_wmask  out  4  downstream byte mask.
- dev_wen  out  1  downstream write request.
- dev_ren  out  1  downstream read request.
- dev_rdata  in  32  downstream read data.
- dev_ready  in  1  downstream completion pulse.
- grant  out  2  one-hot current owner; 00 when idle.
- bus_error  out  1  one-cycle pulse on a watchdog completion.
- err_count  out  8  saturating count of watchdog completions.

Behaviour:
- States: IDLE, GRANT0, GRANT1. Registered state; a last_grant bit holds the round-robin pointer.
- Reset (rst_n low at a clk edge):
  - state=IDLE, last_grant=1 (port 0 wins the first tie), counter=0, err_count=0, bus_error=0.
  - Every dev_* output, every h*_ready, h*_rdata and grant are 0 from the cycle after that edge.
  - Reset mid-transaction aborts the grant with no ready to any requester; a dev_ready arriving during or after reset is ignored.
- A port requests when (ren|wen) is high.
- IDLE, arbitration:
  - Only port 0 requesting -> GRANT0. Only port 1 requesting -> GRANT1.
  - Both requesting with FIXED_PRIORITY=1 -> GRANT0.
  - Both requesting with FIXED_PRIORITY=0 -> the port not equal to last_grant.
  - Transition takes effect on the next edge; request-to-downstream latency is 1 cycle.
  - While in IDLE all dev_* outputs are 0 and any dev_ready is ignored.
- GRANTk:
  - dev_addr, dev_wdata, dev_wmask, dev_wen and dev_ren are driven combinationally from hk.
  - hk_rdata = dev_rdata and hk_ready = dev_ready, combinational, zero added latency.
  - The non-granted port sees ready=0 and rdata=0.
- GRANTk exit on dev_ready=1: next state IDLE, last_grant=k. A requester re-requesting wins again only under the arbitration rules above.
- Watchdog:
  - The counter clears on entry to GRANTk and increments each GRANT cycle without dev_ready.
  - In the cycle where counter==TIMEOUT_CYCLES-1 and dev_ready=0 (TIMEOUT_CYCLES≠0), the arbiter drives hk_ready=1 and hk_rdata=0, forces dev_wen=dev_ren=0, and pulses bus_error.
  - err_count increments, saturating at 255. Next state IDLE, last_grant=k.
  - dev_ready and timeout in the same cycle: the normal completion wins; no error, no err_count change.
- Requester withdraws (hk ren|wen drops while in GRANTk, a protocol violation): next state IDLE, no ready, no error. dev_* follows hk, so it is 0 that cycle.
- wen and ren both high: both are passed through unchanged; the arbiter does not interpret them.
- grant = 01 in GRANT0, 10 in GRANT1.

Test Plan:
- Port 0 read of 0x0000_0100, device returns dev_ready with rdata 0xDEADBEEF two cycles after dev_ren rises -> dev_ren high 1 cycle after h0_ren; h0_ready pulse with h0_rdata=0xDEADBEEF in the same cycle as dev_ready; state IDLE next; h1_ready stays 0.
- After reset, h0 and h1 both request every cycle, device ready after 1 cycle, FIXED_PRIORITY=0 -> grants alternate 01,10,01,10; each port completes 4 transactions in 16 cycles.
- Same as above with FIXED_PRIORITY=1 -> grant stays 01; h1 never readies while h0 keeps requesting.
- TIMEOUT_CYCLES=16, h1 reads 0x8000_0000 and dev_ready is never asserted -> h1_ready=1 and h1_rdata=0 on the 16th GRANT1 cycle, bus_error 1-cycle pulse, err_count=1, dev_ren=0 that cycle.
- TIMEOUT_CYCLES=16, dev_ready lands exactly on the 16th GRANT1 cycle -> h1_ready with dev_rdata, bus_error=0, err_count unchanged.
- Drive rst_n low in the 2nd GRANT0 cycle of a write to 0x40, with dev_ready pulsed during reset -> dev_wen=0 and grant=00 from the next cycle, no h0_ready, err_count=0; after release, port 0 wins the first tie.
